// File: rtl/dm_unit.sv
// dm_unit: MEM-stage data memory with sw/sh/sb store merging,
// alignment/range checking and an optional store trace.
// Optional feature macro: DM_DISPLAY_EN (prints one line per committed store).
module dm_unit #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [1:0]  StoreType,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  input  logic [31:0] PC,
  output logic [31:0] ReadData,
  output logic [31:0] DisA,
  output logic [31:0] DisWD,
  output logic        AddrErr
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

  localparam logic [1:0] ST_SW  = 2'b00;
  localparam logic [1:0] ST_SH  = 2'b01;
  localparam logic [1:0] ST_SB  = 2'b10;

  // Word array; read combinationally so MEM/WB can latch it this cycle.
  logic [31:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-3:0] idx;
  logic [31:0]           old_word;
  logic                  range_err;
  logic                  align_err;
  logic                  write_en;

  assign idx      = Addr[ADDR_WIDTH-1:2];
  assign old_word = mem_q[idx];
  assign ReadData = old_word;
  assign DisA     = {Addr[31:2], 2'b00};

  // Any address bit above the memory window means out of range (no wrap).
  assign range_err = (Addr >> ADDR_WIDTH) != 32'd0;

  // Alignment / reserved-type check, independent of MemWrite so loads can reuse it.
  always_comb begin
    align_err = 1'b0;
    case (StoreType)
      ST_SW:   align_err = (Addr[1:0] != 2'b00);
      ST_SH:   align_err = Addr[0];
      ST_SB:   align_err = 1'b0;
      default: align_err = 1'b1;
    endcase
  end

  assign AddrErr  = align_err | range_err;
  assign write_en = MemWrite & ~AddrErr;

  // Merge store data into the currently stored word (little-endian lanes).
  always_comb begin
    DisWD = old_word;
    case (StoreType)
      ST_SW: DisWD = WD;
      ST_SH: begin
        if (Addr[1]) DisWD[31:16] = WD[15:0];
        else         DisWD[15:0]  = WD[15:0];
      end
      ST_SB: begin
        case (Addr[1:0])
          2'd0:    DisWD[7:0]   = WD[7:0];
          2'd1:    DisWD[15:8]  = WD[7:0];
          2'd2:    DisWD[23:16] = WD[7:0];
          default: DisWD[31:24] = WD[7:0];
        endcase
      end
      default: DisWD = old_word;
    endcase
  end

  // Reset clears every word and wins over a simultaneous store; otherwise commit the merge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else if (write_en) begin
      mem_q[idx] <= DisWD;
    end
  end

`ifdef DM_DISPLAY_EN
  // Store trace: one line per committed store, nothing for dropped stores or reset.
  always_ff @(posedge clk) begin
    if (!reset && write_en) begin
      $display("%0t@%h: *%h <= %h", $time, PC, DisA, DisWD);
    end
  end
`else
  // PC only feeds the trace.
  logic unused_pc;
  assign unused_pc = ^PC;
`endif

endmodule

// File: tb/tb_dm_unit.sv
// tb_dm_unit: directed self-checking bench for dm_unit.
module tb_dm_unit;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [1:0]  StoreType;
  logic [31:0] Addr;
  logic [31:0] WD;
  logic [31:0] PC;
  logic [31:0] ReadData;
  logic [31:0] DisA;
  logic [31:0] DisWD;
  logic        AddrErr;

  int total_cnt = 0;
  int bad_cnt   = 0;

  dm_unit #(.ADDR_WIDTH(12)) dut (
    .clk      (clk),
    .reset    (reset),
    .MemWrite (MemWrite),
    .StoreType(StoreType),
    .Addr     (Addr),
    .WD       (WD),
    .PC       (PC),
    .ReadData (ReadData),
    .DisA     (DisA),
    .DisWD    (DisWD),
    .AddrErr  (AddrErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Advance one clock edge; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [1:0] st, input logic [31:0] a, input logic [31:0] d);
    MemWrite  = we;
    StoreType = st;
    Addr      = a;
    WD        = d;
    PC        = PC + 32'd4;
    #1;
  endtask

  task automatic read_word(input string tag, input logic [31:0] a, input logic [31:0] exp);
    drive(1'b0, 2'b00, a, 32'd0);
    check_val(tag, ReadData, exp);
  endtask

  initial begin
    int sweep_bad;
    reset = 1'b1; MemWrite = 1'b0; StoreType = 2'b00; Addr = 32'd0; WD = 32'd0; PC = 32'h0000_1000;
    tick();
    reset = 1'b0;

    // Reset sweep: every word reads 0 with no address error.
    sweep_bad = 0;
    for (int a = 0; a < 4096; a += 4) begin
      drive(1'b0, 2'b00, a, 32'd0);
      if (ReadData !== 32'd0 || AddrErr !== 1'b0) sweep_bad++;
    end
    check_val("reset_sweep_nonzero_words", sweep_bad, 32'd0);

    // Word store: same-cycle outputs, then readback.
    drive(1'b1, 2'b00, 32'h010, 32'h12345678);
    check_val("sw_disa", DisA, 32'h010);
    check_val("sw_diswd", DisWD, 32'h12345678);
    check_val("sw_old_rd", ReadData, 32'h0);
    check_val("sw_err", AddrErr, 32'd0);
    tick();
    read_word("sw_readback", 32'h010, 32'h12345678);

    // Byte then halfword merge.
    drive(1'b1, 2'b10, 32'h013, 32'h000000AB);
    check_val("sb_disa", DisA, 32'h010);
    check_val("sb_diswd", DisWD, 32'hAB345678);
    tick();
    drive(1'b1, 2'b01, 32'h010, 32'h0000CDEF);
    check_val("sh_diswd", DisWD, 32'hAB34CDEF);
    tick();
    read_word("merge_readback", 32'h010, 32'hAB34CDEF);

    // Error cases: flagged and dropped.
    drive(1'b1, 2'b00, 32'h012, 32'hDEADBEEF);
    check_val("sw_mis_err", AddrErr, 32'd1);
    tick();
    read_word("sw_mis_unchanged", 32'h010, 32'hAB34CDEF);
    drive(1'b1, 2'b01, 32'h011, 32'hDEADBEEF);
    check_val("sh_mis_err", AddrErr, 32'd1);
    tick();
    read_word("sh_mis_unchanged", 32'h010, 32'hAB34CDEF);
    drive(1'b1, 2'b11, 32'h010, 32'hDEADBEEF);
    check_val("rsv_type_err", AddrErr, 32'd1);
    tick();
    read_word("rsv_unchanged", 32'h010, 32'hAB34CDEF);
    drive(1'b1, 2'b00, 32'h1000, 32'hDEADBEEF);
    check_val("range_err", AddrErr, 32'd1);
    tick();
    read_word("range_no_wrap", 32'h000, 32'h0);
    drive(1'b0, 2'b10, 32'h8000_0010, 32'h0);
    check_val("range_hi_err", AddrErr, 32'd1);
    drive(1'b0, 2'b10, 32'h011, 32'h0);
    check_val("sb_odd_ok", AddrErr, 32'd0);

    // Highest in-range word.
    drive(1'b1, 2'b00, 32'hFFC, 32'hCAFEF00D);
    check_val("top_word_err", AddrErr, 32'd0);
    tick();
    read_word("top_word_readback", 32'hFFC, 32'hCAFEF00D);

    // Reset collision: store lost, memory cleared.
    reset = 1'b1;
    drive(1'b1, 2'b00, 32'h020, 32'hFFFFFFFF);
    tick();
    reset = 1'b0;
    read_word("rst_collision_020", 32'h020, 32'h0);
    read_word("rst_clears_010", 32'h010, 32'h0);
    read_word("rst_clears_ffc", 32'hFFC, 32'h0);

    // Back-to-back byte stores to one word, then upper halfword.
    drive(1'b1, 2'b10, 32'h031, 32'h00000011);
    check_val("b2b_first_diswd", DisWD, 32'h00001100);
    tick();
    drive(1'b1, 2'b10, 32'h032, 32'h00000022);
    check_val("b2b_second_diswd", DisWD, 32'h00221100);
    tick();
    read_word("b2b_readback", 32'h030, 32'h00221100);
    drive(1'b1, 2'b01, 32'h032, 32'hFFFF5555);
    check_val("sh_upper_diswd", DisWD, 32'h55551100);
    tick();
    read_word("sh_upper_readback", 32'h030, 32'h55551100);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dm_unit.md
# dm_unit

Data-memory unit for the MEM stage of the five-stage pipeline. It sits directly upstream of the MEM/WB pipeline register and produces its `ReadData_M`, `DisA_M` and `DisWD_M` inputs. It holds a synchronous-write, combinational-read word array and performs byte/halfword/word store merging, alignment and range checking. It also provides an optional store trace.

## Interface
Parameters:
- `ADDR_WIDTH`, default 12: byte-address width of the memory (2^ADDR_WIDTH bytes; 1024 words at default).

Ports:
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  synchronous, active-high; clears every word to 0.
- `MemWrite`  input  1  store request from the EX/MEM register.
- `StoreType`  input  2  00 = sw, 01 = sh, 10 = sb, 11 = reserved.
- `Addr`  input  32  byte address (ALU result).
- `WD`  input  32  store data; the low byte/halfword is used for sb/sh.
- `PC`  input  32  PC of the instruction in MEM; trace use only.
- `ReadData`  output  32  raw word at `Addr[ADDR_WIDTH-1:2]`; load extension happens in WB.
- `DisA`  output  32  word-aligned store address `{Addr[31:2],2'b00}`.
- `DisWD`  output  32  merged word that is (or would be) written.
- `AddrErr`  output  1  misaligned, out-of-range or reserved-type access.

## Operation
- Storage is `mem[0 : 2^(ADDR_WIDTH-2)-1]` × 32 bits, indexed by `Addr[ADDR_WIDTH-1:2]`.
- `ReadData` is a combinational read of the currently stored word, valid in the same cycle for MEM→WB latching.
- Merge rule for `DisWD`, with `old = mem[idx]`:
  - sw: `WD`.
  - sh: halfword `Addr[1]` is replaced by `WD[15:0]`; the other halfword is kept from `old`.
  - sb: byte `Addr[1:0]` is replaced by `WD[7:0]`; the other bytes are kept from `old`.
  - Byte 0 is `[7:0]` (little-endian lanes).
- `AddrErr` is 1 when any of these holds:
  - sw with `Addr[1:0]≠0`;
  - sh with `Addr[0]≠0`;
  - `Addr[31:ADDR_WIDTH]≠0`;
  - `StoreType=11`.
- `AddrErr` is evaluated regardless of `MemWrite`. A CPU can therefore also use it for load checks by driving the matching type.
- Write commit: on the rising edge, if `!reset && MemWrite && !AddrErr`, then `mem[idx] <= DisWD`.
- A store with `AddrErr=1` is dropped; the memory is unchanged.
- Only the addressed word is ever modified.

## Timing
- Reset:
  - on the edge with `reset=1`, all words become 0;
  - `reset` overrides a simultaneous `MemWrite`;
  - in the following cycle, `ReadData=0` for every address.
- Reset value of every output:
  - `ReadData=0` and `DisWD`=merge of `WD` with 0;
  - `DisA` and `AddrErr` are purely combinational from their inputs.
- Store latency: 1 edge. A read of the same word in the store cycle returns the old value; the next cycle returns the new value. No internal forwarding is done (consistent with in-order single-store-per-cycle MEM).
- Back-to-back stores to the same word on consecutive cycles: the second merge uses the word committed by the first.
- Mid-operation reset: a store presented in the reset cycle is lost. No partial word write is allowed.
- Highest in-range word (`Addr=2^ADDR_WIDTH-4`) is valid. `Addr=2^ADDR_WIDTH` flags `AddrErr`; there is no wrap-around.

## Configuration
- `DM_DISPLAY_EN`:
  - Defined: on each committed store edge, the unit prints `"<time>@<PC>: *<DisA> <= <DisWD>"` (hex, 8 digits) via `$display`. Dropped stores and reset cycles print nothing.
  - Undefined: no trace logic is compiled. Functional behaviour is identical either way.

## Test plan
- Reset then read: assert `reset` 1 cycle, sweep `Addr` 0x000..0xFFC → `ReadData=0`, `AddrErr=0` throughout.
- Word store/readback:
  - sw `Addr=0x010`, `WD=0x12345678` → in the same cycle `DisA=0x010`, `DisWD=0x12345678`, old `ReadData=0`;
  - next cycle `ReadData=0x12345678`.
- Byte/half merge:
  - after the word store above, sb `Addr=0x013`, `WD=0xAB` → `0xAB345678`;
  - then sh `Addr=0x010`, `WD=0xCDEF` → `0xAB34CDEF`.
- Alignment and range errors; each of these gives `AddrErr=1` and the word is unchanged next cycle:
  - sw `Addr=0x012`;
  - sh `Addr=0x011`;
  - `StoreType=11`;
  - sw `Addr=0x1000`.
- Reset collision: in the same cycle, `reset=1` and sw `Addr=0x020`, `WD=0xFFFFFFFF` → next cycle `ReadData`@0x020 = 0, and no trace line with `DM_DISPLAY_EN`.
- Back-to-back:
  - sb `0x031`←`0x11`, then sb `0x032`←`0x22` on consecutive cycles → word 0x030 = `0x00221100`;
  - with `DM_DISPLAY_EN`, exactly two trace lines.
